// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory access stage of a single-cycle core. Turns one load or store
//   per instruction into a registered req/ack bus transaction with byte-lane
//   strobes, extracts and sign/zero-extends load data, and holds the core
//   (stall) until the access retires.
//
//   Build option: define MISALIGN_TRAP_EN to trap misaligned half/word
//   accesses (IDLE->DONE with misaligned=1, no bus transaction). When it is
//   not defined, the offending low address bits are ignored and the access
//   proceeds normally; misaligned stays 0.
//
// Ports
//   clk, rst_n               core clock, asynchronous active-low reset
//   mem_rd_en, mem_wr_en     load / store request (both set => store)
//   rd_sel [2:0]             0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu
//   wr_sel [1:0]             0 sw, 1 sb, 2 sh
//   addr, wdata [31:0]       effective byte address, store data
//   stall                    hold PC/instruction this cycle
//   load_data, bus_err,
//   misaligned               retire results, valid while in DONE
//   bus_req/we/addr/be/wdata registered bus request fields
//   bus_ack, bus_rdata       completion pulse and read word from memory
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [2:0]  rd_sel,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              bus_err_q, bus_err_d;
  logic              misaligned_q, misaligned_d;
  logic [1:0]        off_q, off_d;       // byte offset used for load extraction
  logic [2:0]        rd_sel_q, rd_sel_d;
  logic              is_store_q, is_store_d;

  // ---------------------------------------------------------------------
  // Access decode (combinational, from the current instruction)
  // ---------------------------------------------------------------------
  logic        access;
  logic        acc_byte, acc_half;
  logic [1:0]  eff_off;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic        trap_now;

  always_comb begin
    access   = mem_rd_en | mem_wr_en;
    // A store wins when both enables are set, so size comes from wr_sel then.
    acc_byte = mem_wr_en ? (wr_sel == 2'd1) : (rd_sel == 3'd0 || rd_sel == 3'd3);
    acc_half = mem_wr_en ? (wr_sel == 2'd2) : (rd_sel == 3'd1 || rd_sel == 3'd4);

    // Halves only honour addr[1]; words always sit in lane 0.
    if (acc_byte)      eff_off = addr[1:0];
    else if (acc_half) eff_off = {addr[1], 1'b0};
    else               eff_off = 2'b00;

    be_new    = 4'b1111;
    wdata_new = wdata;
    if (mem_wr_en) begin
      if (acc_byte) begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end else if (acc_half) begin
        be_new    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata[15:0]}};
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis;
  assign mis      = acc_half ? addr[0] : (!acc_byte && (addr[1:0] != 2'b00));
  assign trap_now = access & mis;
`else
  assign trap_now = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Load data extraction from the acknowledged read word
  // ---------------------------------------------------------------------
  logic [31:0] shifted;
  logic [31:0] extracted;

  always_comb begin
    shifted = bus_rdata >> {off_q, 3'b000};
    case (rd_sel_q)
      3'd0:    extracted = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    extracted = {{16{shifted[15]}}, shifted[15:0]};
      3'd3:    extracted = {24'd0, shifted[7:0]};
      3'd4:    extracted = {16'd0, shifted[15:0]};
      default: extracted = shifted;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    load_data_d  = load_data_q;
    bus_err_d    = bus_err_q;
    misaligned_d = misaligned_q;
    off_d        = off_q;
    rd_sel_d     = rd_sel_q;
    is_store_d   = is_store_q;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (trap_now) begin
            state_d      = DONE;
            misaligned_d = 1'b1;
            load_data_d  = 32'd0;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wr_en;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = be_new;
            bus_wdata_d = wdata_new;
            off_d       = eff_off;
            rd_sel_d    = rd_sel;
            is_store_d  = mem_wr_en;
          end
        end
      end
      REQ: begin
        // An ack on the last allowed cycle still completes normally.
        if (bus_ack) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          load_data_d = is_store_q ? 32'd0 : extracted;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          bus_err_d   = 1'b1;
          load_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // The core retires on this edge; the held instruction is not relaunched.
        state_d      = IDLE;
        load_data_d  = 32'd0;
        bus_err_d    = 1'b0;
        misaligned_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_be_q     <= 4'd0;
      bus_wdata_q  <= 32'd0;
      load_data_q  <= 32'd0;
      bus_err_q    <= 1'b0;
      misaligned_q <= 1'b0;
      off_q        <= 2'd0;
      rd_sel_q     <= 3'd0;
      is_store_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      load_data_q  <= load_data_d;
      bus_err_q    <= bus_err_d;
      misaligned_q <= misaligned_d;
      off_q        <= off_d;
      rd_sel_q     <= rd_sel_d;
      is_store_q   <= is_store_d;
    end
  end

  assign stall      = ((state_q == IDLE) && access) || (state_q == REQ);
  assign load_data  = load_data_q;
  assign bus_err    = bus_err_q;
  assign misaligned = misaligned_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Table of hand-computed vectors, a reset-during-request sequence and a
//   randomized run checked against a transaction-level reference model.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd_en, mem_wr_en;
  logic [2:0]  rd_sel;
  logic [1:0]  wr_sel;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        bus_err, misaligned;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .rd_sel(rd_sel), .wr_sel(wr_sel), .addr(addr), .wdata(wdata),
    .stall(stall), .load_data(load_data), .bus_err(bus_err), .misaligned(misaligned),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  rsel;
    logic [1:0]  wsel;
    logic [31:0] addr, wdata, rdata;
    int          ack_dly;    // ack in this REQ cycle (1-based); 0 = never
    logic        exp_req, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_ld;
    logic        exp_err, exp_mis;
    int          exp_stall;
  } txn_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(
      input logic rd, input logic wr, input logic [2:0] rsel, input logic [1:0] wsel,
      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat, input int ack,
      input logic ereq, input logic ewe, input logic [3:0] ebe, input logic [31:0] ewd,
      input logic [31:0] eld, input logic eerr, input logic emis, input int estall);
    txn_t t;
    t.rd = rd; t.wr = wr; t.rsel = rsel; t.wsel = wsel;
    t.addr = a; t.wdata = wd; t.rdata = rdat; t.ack_dly = ack;
    t.exp_req = ereq; t.exp_we = ewe; t.exp_be = ebe; t.exp_wdata = ewd;
    t.exp_ld = eld; t.exp_err = eerr; t.exp_mis = emis; t.exp_stall = estall;
    return t;
  endfunction

  // Reference model: derives the expected retire result of a whole access
  // from access size, byte offset and the ack timing, using plain arithmetic.
  function automatic txn_t model(input txn_t t);
    txn_t   r;
    int     size, off;
    bit     st, sgn, mis, trap, tmo;
    longint v, mask;
    logic [3:0] lanes;
    r   = t;
    st  = t.wr;
    if (st) size = (t.wsel == 2'd1) ? 1 : (t.wsel == 2'd2) ? 2 : 4;
    else    size = (t.rsel == 3'd0 || t.rsel == 3'd3) ? 1 :
                   (t.rsel == 3'd1 || t.rsel == 3'd4) ? 2 : 4;
    sgn = !st && (t.rsel == 3'd0 || t.rsel == 3'd1);
    off = int'(t.addr % 32'd4);
    mis = (off % size) != 0;
`ifdef MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    off   = off - (off % size);
    tmo   = (t.ack_dly < 1) || (t.ack_dly > TIMEOUT);
    lanes = 4'((1 << size) - 1);
    r.exp_req   = !trap;
    r.exp_we    = st;
    r.exp_be    = st ? 4'(lanes << off) : 4'hF;
    r.exp_mis   = trap;
    r.exp_err   = !trap && tmo;
    r.exp_stall = trap ? 1 : 1 + (tmo ? TIMEOUT : t.ack_dly);
    if (size == 1)      r.exp_wdata = (t.wdata & 32'hFF) * 32'h01010101;
    else if (size == 2) r.exp_wdata = (t.wdata & 32'hFFFF) * 32'h00010001;
    else                r.exp_wdata = t.wdata;
    if (trap || tmo || st) begin
      r.exp_ld = 32'd0;
    end else begin
      mask = (64'sd1 <<< (8 * size)) - 64'sd1;
      v    = longint'(t.rdata >> (8 * off)) & mask;
      if (sgn && v >= (64'sd1 <<< (8 * size - 1))) v = v - (64'sd1 <<< (8 * size));
      r.exp_ld = 32'(v);
    end
    return r;
  endfunction

  // Drives one instruction from IDLE until it retires, acting as the memory.
  // Called and returns at a falling edge.
  task automatic run_txn(input string tag, input txn_t t);
    int stall_cnt = 0;
    int req_cyc   = 0;
    bit seen_req  = 1'b0;
    bit done      = 1'b0;
    mem_rd_en = t.rd; mem_wr_en = t.wr; rd_sel = t.rsel; wr_sel = t.wsel;
    addr = t.addr; wdata = t.wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (bus_req) begin
        req_cyc++;
        if (!seen_req) begin
          seen_req = 1'b1;
          chk({tag, ".bus_addr"}, 64'(bus_addr), 64'({t.addr[31:2], 2'b00}));
          chk({tag, ".bus_be"}, 64'(bus_be), 64'(t.exp_be));
          chk({tag, ".bus_we"}, 64'(bus_we), 64'(t.exp_we));
          if (t.exp_we) chk({tag, ".bus_wdata"}, 64'(bus_wdata), 64'(t.exp_wdata));
        end
        bus_ack   = (req_cyc == t.ack_dly);
        bus_rdata = bus_ack ? t.rdata : $urandom;
      end else begin
        // Stray acks outside a request must be ignored.
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      if (stall) begin
        stall_cnt++;
      end else begin
        done = 1'b1;
        chk({tag, ".load_data"}, 64'(load_data), 64'(t.exp_ld));
        chk({tag, ".bus_err"}, 64'(bus_err), 64'(t.exp_err));
        chk({tag, ".misaligned"}, 64'(misaligned), 64'(t.exp_mis));
        chk({tag, ".stall_cycles"}, 64'(stall_cnt), 64'(t.exp_stall));
        chk({tag, ".bus_req_seen"}, 64'(seen_req), 64'(t.exp_req));
        mem_rd_en = 1'b0; mem_wr_en = 1'b0;
      end
      @(negedge clk);
    end
    if (!done) begin
      chk({tag, ".retire_within_bound"}, 64'(0), 64'(1));
      mem_rd_en = 1'b0; mem_wr_en = 1'b0;
      @(negedge clk);
    end
    #1;
    chk({tag, ".cleared_after_done"},
        64'({load_data, bus_err, misaligned, stall, bus_req}), 64'(0));
    bus_ack = 1'b0;
    $display("txn %s addr=0x%08h ld=0x%08h err=%0b mis=%0b stall=%0d", tag, t.addr,
             t.exp_ld, t.exp_err, t.exp_mis, stall_cnt);
    @(negedge clk);
  endtask

  txn_t vec[$];

  initial begin
    txn_t t;
    int   r;

    rst_n = 1'b0;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; rd_sel = 3'd0; wr_sel = 2'd0;
    addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;

    //         rd wr rsel wsel addr        wdata         rdata         ack  req we be     wdata         ld            err mis stall
    vec.push_back(mk(1, 0, 2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 2,  1, 0, 4'hF, 32'h0,        32'hDEADBEEF, 0, 0, 3));
    vec.push_back(mk(1, 0, 0, 0, 32'h103, 32'h0,        32'h80000000, 1,  1, 0, 4'hF, 32'h0,        32'hFFFFFF80, 0, 0, 2));
    vec.push_back(mk(1, 0, 3, 0, 32'h103, 32'h0,        32'h80000000, 1,  1, 0, 4'hF, 32'h0,        32'h00000080, 0, 0, 2));
    vec.push_back(mk(0, 1, 0, 2, 32'h102, 32'h1234ABCD, 32'h55555555, 1,  1, 1, 4'hC, 32'hABCDABCD, 32'h0,        0, 0, 2));
    vec.push_back(mk(1, 0, 2, 0, 32'h200, 32'h0,        32'h12345678, 0,  1, 0, 4'hF, 32'h0,        32'h0,        1, 0, 1 + TIMEOUT));
    vec.push_back(mk(0, 1, 0, 1, 32'h101, 32'h00000055, 32'h0,        3,  1, 1, 4'h2, 32'h55555555, 32'h0,        0, 0, 4));
    vec.push_back(mk(1, 0, 4, 0, 32'h102, 32'h0,        32'h89AB1234, 1,  1, 0, 4'hF, 32'h0,        32'h000089AB, 0, 0, 2));
    vec.push_back(mk(1, 0, 1, 0, 32'h102, 32'h0,        32'h89AB1234, 1,  1, 0, 4'hF, 32'h0,        32'hFFFF89AB, 0, 0, 2));
    vec.push_back(mk(1, 1, 2, 0, 32'h040, 32'hCAFEF00D, 32'h11111111, TIMEOUT, 1, 1, 4'hF, 32'hCAFEF00D, 32'h0, 0, 0, 1 + TIMEOUT));
    vec.push_back(mk(1, 0, 0, 0, 32'h101, 32'h0,        32'h00007F00, 1,  1, 0, 4'hF, 32'h0,        32'h0000007F, 0, 0, 2));
`ifdef MISALIGN_TRAP_EN
    vec.push_back(mk(1, 0, 1, 0, 32'h101, 32'h0,        32'h1234F678, 1,  0, 0, 4'hF, 32'h0,        32'h0,        0, 1, 1));
`else
    vec.push_back(mk(1, 0, 1, 0, 32'h101, 32'h0,        32'h1234F678, 1,  1, 0, 4'hF, 32'h0,        32'hFFFFF678, 0, 0, 2));
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset.bus_ctrl", 64'({bus_req, bus_we, bus_be, bus_addr}), 64'(0));
    chk("reset.bus_wdata", 64'(bus_wdata), 64'(0));
    chk("reset.results", 64'({load_data, bus_err, misaligned, stall}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vec[i]) run_txn($sformatf("vec%0d", i), vec[i]);

    // Reset asserted while a load is waiting in REQ, then released with the
    // load still presented: it must launch again from IDLE.
    begin
      bit got = 1'b0;
      mem_rd_en = 1'b1; mem_wr_en = 1'b0; rd_sel = 3'd2; wr_sel = 2'd0;
      addr = 32'h300; wdata = 32'h77777777;
      for (int c = 0; c < 5 && !got; c++) begin
        @(negedge clk);
        #1;
        if (bus_req) got = 1'b1;
      end
      chk("rst_mid.req_raised", 64'(got), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("rst_mid.bus_req", 64'(bus_req), 64'(0));
      chk("rst_mid.bus_fields", 64'({bus_we, bus_be, bus_addr}), 64'(0));
      chk("rst_mid.bus_wdata", 64'(bus_wdata), 64'(0));
      chk("rst_mid.results", 64'({load_data, bus_err, misaligned}), 64'(0));
      chk("rst_mid.stall_idle_access", 64'(stall), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      run_txn("rst_relaunch",
              mk(1, 0, 2, 0, 32'h300, 32'h77777777, 32'h0BADF00D, 1,
                 1, 0, 4'hF, 32'h0, 32'h0BADF00D, 0, 0, 2));
    end

    // Randomized accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      r         = int'($urandom_range(1, 3));
      t.rd      = r[0];
      t.wr      = r[1];
      t.rsel    = 3'($urandom_range(0, 4));
      t.wsel    = 2'($urandom_range(0, 2));
      t.addr    = $urandom;
      t.wdata   = $urandom;
      t.rdata   = $urandom;
      case ($urandom_range(0, 9))
        0:       t.ack_dly = 0;
        1:       t.ack_dly = TIMEOUT;
        default: t.ack_dly = int'($urandom_range(1, 4));
      endcase
      run_txn($sformatf("rand%0d", n), model(t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
